// File: rtl/seg7_scan_display.sv
// Three-digit multiplexed 7-segment driver for an 8-bit count.
// A double-dabble FSM converts value to BCD, and a divided scan clock walks the digit slots.
module seg7_scan_display #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk50m,
   input  logic       reset,
   input  logic [7:0] value,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   state_t      state_q, state_d;
   logic [7:0]  src_q, src_d;
   logic [7:0]  shadow_q, shadow_d;
   logic [11:0] bcd_q, bcd_d;
   logic [11:0] hold_q, hold_d;
   logic [2:0]  bit_q, bit_d;
   logic [11:0] bcd_adj;

   logic [15:0] tick_cnt_q;
   logic        tick_q;
   logic        tick;
   logic [1:0]  digit_q;
   logic [6:0]  seg_q, seg_d;
   logic [3:0]  an_q, an_d;
   logic [3:0]  nib;
   logic        blank;

   function automatic logic [11:0] add3(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int i = 0; i < 3; i++) begin
         if (r[i*4 +: 4] >= 4'd5)
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [6:0] enc7(input logic [3:0] d);
      case (d)
         4'd0:    enc7 = 7'h40;
         4'd1:    enc7 = 7'h79;
         4'd2:    enc7 = 7'h24;
         4'd3:    enc7 = 7'h30;
         4'd4:    enc7 = 7'h19;
         4'd5:    enc7 = 7'h12;
         4'd6:    enc7 = 7'h02;
         4'd7:    enc7 = 7'h78;
         4'd8:    enc7 = 7'h00;
         4'd9:    enc7 = 7'h10;
         default: enc7 = 7'h7F;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      shadow_d = shadow_q;
      bcd_d    = bcd_q;
      hold_d   = hold_q;
      bit_d    = bit_q;
      bcd_adj  = add3(bcd_q);
      case (state_q)
         IDLE: begin
            if (value != shadow_q) begin
               src_d    = value;
               shadow_d = value;
               bcd_d    = '0;
               bit_d    = '0;
               state_d  = CONV;
            end
         end
         CONV: begin
            {bcd_d, src_d} = {bcd_adj, src_q} << 1;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7)
               state_d = LOAD;
         end
         LOAD: begin
            hold_d  = bcd_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk50m or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         src_q    <= '0;
         shadow_q <= '0;
         bcd_q    <= '0;
         hold_q   <= '0;
         bit_q    <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         shadow_q <= shadow_d;
         bcd_q    <= bcd_d;
         hold_q   <= hold_d;
         bit_q    <= bit_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign tick = (tick_cnt_q == 16'(SCAN_DIV - 1));

   // Slot decode from the current index; blanking suppresses leading zeros only.
   always_comb begin
      case (digit_q)
         2'd0:    nib = hold_q[3:0];
         2'd1:    nib = hold_q[7:4];
         default: nib = hold_q[11:8];
      endcase
      case (digit_q)
         2'd1:    blank = (hold_q[11:4] == 8'd0);
         2'd2:    blank = (hold_q[11:8] == 4'd0);
         default: blank = 1'b0;
      endcase
      seg_d = 7'h7F;
      an_d  = 4'hF;
      if (!blank) begin
         seg_d = enc7(nib);
         an_d  = ~(4'b0001 << digit_q);
      end
   end

   // The tick pulse loads the slot at the index and steps it, so slot 0 shows first after reset.
   always_ff @(posedge clk50m or posedge reset) begin
      if (reset) begin
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
         digit_q    <= '0;
         seg_q      <= 7'h7F;
         an_q       <= 4'hF;
      end else begin
         tick_cnt_q <= tick ? 16'd0 : tick_cnt_q + 16'd1;
         tick_q     <= tick;
         if (tick_q) begin
            seg_q   <= seg_d;
            an_q    <= an_d;
            digit_q <= (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
         end
      end
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign dp  = 1'b1;

endmodule
